// File: rtl/screen_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : screen_fb_arbiter_if
// Description : Bundle of the display read port, the CPU bus port and the
//               single-port framebuffer RAM port used by screen_fb_arbiter.
//               slave  : arbiter side (takes requests, drives the RAM)
//               master : requester / RAM side (testbench or system glue)
//               Display : disp_req, disp_addr -> disp_ack, disp_data
//               CPU     : cpu_valid, cpu_we, cpu_addr, cpu_wdata
//                         -> cpu_ready, cpu_rdata
//               RAM     : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface screen_fb_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 18
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_ack;
    logic [DATA_W-1:0] disp_data;

    logic              cpu_valid;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr,
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata,
        output disp_ack, disp_data,
        output cpu_ready, cpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output disp_req, disp_addr,
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata,
        input  disp_ack, disp_data,
        input  cpu_ready, cpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/screen_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : screen_fb_arbiter
// Description : Arbitrates a display scan reader and a CPU bus onto one
//               single-port framebuffer RAM (1-cycle read latency). Every
//               access takes IDLE -> ISSUE -> ACK -> IDLE (3 cycles). Display
//               wins ties, but after MAX_CPU_WAIT consecutive display grants
//               with the CPU waiting, the CPU is granted.
// Ports       : clk   - clock, all state changes on posedge
//               reset - asynchronous active-low reset
//               bus   - screen_fb_arbiter_if.slave (display, CPU, RAM ports)
// Revision    : 1.0 - initial release
// ============================================================================
module screen_fb_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 18,
    parameter int MAX_CPU_WAIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    screen_fb_arbiter_if.slave bus
);

    localparam int c_WAIT_W = (MAX_CPU_WAIT < 1) ? 1 : $clog2(MAX_CPU_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_CPU_WAIT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_D = 3'd1,
        ISSUE_C = 3'd2,
        ACK_D   = 3'd3,
        ACK_C   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                w_mem_en_nxt;
    logic                w_mem_we_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;

    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_cnt_nxt;

    // Direction of the CPU access in flight, captured at grant so the read
    // data capture does not depend on the requester still holding cpu_we.
    logic                r_cpu_rd;
    logic                w_cpu_rd_nxt;

    logic [DATA_W-1:0]   r_disp_data;
    logic [DATA_W-1:0]   r_cpu_rdata;

    // ------------------------------------------------------------------------
    // Next-state and next-output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_cpu_rd_nxt    = r_cpu_rd;

        case (r_state)
            IDLE: begin
                // CPU goes first when alone or when it has been starved long enough.
                if (bus.cpu_valid && (!bus.disp_req || (r_wait_cnt == c_WAIT_MAX))) begin
                    w_state_nxt     = ISSUE_C;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = bus.cpu_we;
                    w_mem_addr_nxt  = bus.cpu_addr;
                    w_mem_wdata_nxt = bus.cpu_wdata;
                    w_wait_cnt_nxt  = '0;
                    w_cpu_rd_nxt    = ~bus.cpu_we;
                end else if (bus.disp_req) begin
                    w_state_nxt    = ISSUE_D;
                    w_mem_en_nxt   = 1'b1;
                    w_mem_addr_nxt = bus.disp_addr;
                    if (bus.cpu_valid) begin
                        if (r_wait_cnt != c_WAIT_MAX) begin
                            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                        end
                    end else begin
                        w_wait_cnt_nxt = '0;
                    end
                end
            end
            ISSUE_D: w_state_nxt = ACK_D;
            ISSUE_C: w_state_nxt = ACK_C;
            ACK_D:   w_state_nxt = IDLE;
            ACK_C:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Registered RAM drive, wait counter and read data
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wait_cnt  <= '0;
            r_cpu_rd    <= 1'b0;
            r_disp_data <= '0;
            r_cpu_rdata <= '0;
        end else begin
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_cpu_rd    <= w_cpu_rd_nxt;
            // RAM data for the access issued last cycle is valid during ACK.
            if (r_state == ACK_D) begin
                r_disp_data <= bus.mem_rdata;
            end
            if ((r_state == ACK_C) && r_cpu_rd) begin
                r_cpu_rdata <= bus.mem_rdata;
            end
        end
    end

    // Ack/ready decode straight from the state register so an asynchronous
    // reset in an ACK state drops them immediately.
    assign bus.disp_ack  = (r_state == ACK_D);
    assign bus.cpu_ready = (r_state == ACK_C);
    assign bus.disp_data = r_disp_data;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_screen_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_screen_fb_arbiter
// Description : Self-checking bench for screen_fb_arbiter with a behavioural
//               single-port RAM, a vector table of single accesses, and
//               hand-written contention, reset-abort and random-traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_fb_arbiter;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    screen_fb_arbiter_if #(.ADDR_W(12), .DATA_W(18)) bus ();

    screen_fb_arbiter #(
        .ADDR_W      (12),
        .DATA_W      (18),
        .MAX_CPU_WAIT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural framebuffer: 1-cycle synchronous read, old data on write.
    logic [17:0] ram [0:4095];
    bit          preload = 1'b1;
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 4096; a++) ram[a] <= 18'h0;
            ram[12'h041] <= 18'h3F000;
            ram[12'h123] <= 18'h12345;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        logic        is_cpu;
        logic        we;
        logic [11:0] addr;
        logic [17:0] wdata;
        logic [17:0] exp;
    } vec_t;

    vec_t        vecs [11];
    logic [17:0] sb_q [$];
    logic [17:0] last_disp = 18'h0;
    logic [17:0] last_cpu  = 18'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Protocol monitor, enabled during random traffic.
    bit   mon_en  = 1'b0;
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            check("mutex", 32'(bus.disp_ack & bus.cpu_ready), 0);
            check("mem_en_b2b", 32'(prev_en & bus.mem_en), 0);
            if (!bus.mem_en)
                check("mem_idle_zero", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 0);
        end
        prev_en <= bus.mem_en;
    end

    // Entered at a negedge with the DUT about to sample IDLE on the next edge.
    task automatic run_vec(input vec_t v, input string tag);
        logic [17:0] got;
        if (v.is_cpu) begin
            bus.cpu_valid = 1'b1;
            bus.cpu_we    = v.we;
            bus.cpu_addr  = v.addr;
            bus.cpu_wdata = v.wdata;
            last_cpu      = v.exp;
        end else begin
            bus.disp_req  = 1'b1;
            bus.disp_addr = v.addr;
            last_disp     = v.exp;
        end
        sb_q.push_back(v.exp);
        @(negedge clk);
        check($sformatf("%s mem_en", tag), bus.mem_en, 1);
        check($sformatf("%s mem_we", tag), bus.mem_we, v.is_cpu & v.we);
        check($sformatf("%s mem_addr", tag), bus.mem_addr, v.addr);
        if (v.is_cpu) check($sformatf("%s mem_wdata", tag), bus.mem_wdata, v.wdata);
        check($sformatf("%s early_ack", tag), bus.disp_ack | bus.cpu_ready, 0);
        @(negedge clk);
        check($sformatf("%s disp_ack", tag), bus.disp_ack, !v.is_cpu);
        check($sformatf("%s cpu_ready", tag), bus.cpu_ready, v.is_cpu);
        check($sformatf("%s mem_en_off", tag), bus.mem_en, 0);
        // Drop the request and scramble idle inputs; they must have no effect.
        bus.disp_req  = 1'b0;
        bus.cpu_valid = 1'b0;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 12'($urandom);
        bus.cpu_wdata = 18'($urandom);
        bus.disp_addr = 12'($urandom);
        @(negedge clk);
        check($sformatf("%s ack_gone", tag), bus.disp_ack | bus.cpu_ready, 0);
        check($sformatf("%s idle_mem_en", tag), bus.mem_en, 0);
        if (sb_q.size() == 0) begin
            check($sformatf("%s sb_underflow", tag), 0, 1);
        end else begin
            got = sb_q.pop_front();
            check($sformatf("%s data", tag), v.is_cpu ? bus.cpu_rdata : bus.disp_data, got);
        end
        check($sformatf("%s disp_data_hold", tag), bus.disp_data, last_disp);
        check($sformatf("%s cpu_rdata_hold", tag), bus.cpu_rdata, last_cpu);
    endtask

    // Both requesters held: expect D D D D C D D D D C.
    task automatic run_contention();
        logic [9:0] pat = '0;
        int n = 0, nc = 0, first_c = 0, d_since = 0;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 12'h000;
        bus.cpu_valid = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 12'h041;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.disp_ack) begin
                d_since++;
                check("cont wait_cnt_inc", 32'(dut.r_wait_cnt), d_since);
                if (n < 10) pat[9-n] = 1'b0;
                n++;
            end
            if (bus.cpu_ready) begin
                d_since = 0;
                check("cont wait_cnt_clr", 32'(dut.r_wait_cnt), 0);
                if (n < 10) pat[9-n] = 1'b1;
                n++;
                if (nc == 0) first_c = k;
                nc++;
                if (nc == 2) break;
            end
        end
        bus.disp_req  = 1'b0;
        bus.cpu_valid = 1'b0;
        check("cont grants", n, 10);
        check("cont pattern", 32'(pat), 32'(10'b0000100001));
        check("cont cpu_latency_le15", 32'(first_c <= 15), 1);
        @(negedge clk);
        check("cont cpu_rdata", bus.cpu_rdata, 18'h0003F);
        check("cont disp_data", bus.disp_data, 18'h3FFFF);
        last_cpu  = 18'h0003F;
        last_disp = 18'h3FFFF;
    endtask

    task automatic run_reset_ackc();
        bus.cpu_valid = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 12'h200;
        bus.cpu_wdata = 18'h15555;
        @(negedge clk);
        check("rstc issue_write", bus.mem_en & bus.mem_we, 1);
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.cpu_valid = 1'b0;
        bus.cpu_we    = 1'b0;
        @(negedge clk);
        check("rstc cpu_ready", bus.cpu_ready, 0);
        check("rstc disp_ack", bus.disp_ack, 0);
        check("rstc mem", 32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 0);
        check("rstc mem_wdata", bus.mem_wdata, 0);
        check("rstc cpu_rdata", bus.cpu_rdata, 0);
        check("rstc disp_data", bus.disp_data, 0);
        check("rstc wait_cnt", 32'(dut.r_wait_cnt), 0);
        check("rstc write_kept", ram[12'h200], 18'h15555);
        reset     = 1'b1;
        last_cpu  = 18'h0;
        last_disp = 18'h0;
    endtask

    initial begin
        vec_t pv;
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.cpu_valid = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        reset         = 1'b0;

        //           is_cpu we    addr     wdata      expected data
        vecs[0]  = '{1'b0, 1'b0, 12'h041, 18'h00000, 18'h3F000};
        vecs[1]  = '{1'b1, 1'b1, 12'hFFF, 18'h00FC0, 18'h00000};
        vecs[2]  = '{1'b1, 1'b0, 12'hFFF, 18'h2AAAA, 18'h00FC0};
        vecs[3]  = '{1'b1, 1'b1, 12'h041, 18'h0003F, 18'h00FC0};
        vecs[4]  = '{1'b0, 1'b0, 12'h041, 18'h00000, 18'h0003F};
        vecs[5]  = '{1'b1, 1'b0, 12'h041, 18'h00000, 18'h0003F};
        vecs[6]  = '{1'b0, 1'b0, 12'hFFF, 18'h00000, 18'h00FC0};
        vecs[7]  = '{1'b1, 1'b1, 12'h000, 18'h3FFFF, 18'h0003F};
        vecs[8]  = '{1'b0, 1'b0, 12'h000, 18'h00000, 18'h3FFFF};
        vecs[9]  = '{1'b1, 1'b0, 12'h123, 18'h00000, 18'h12345};
        vecs[10] = '{1'b0, 1'b0, 12'h123, 18'h00000, 18'h12345};

        @(negedge clk);
        preload = 1'b0;
        repeat (2) @(negedge clk);
        check("rst acks", 32'({bus.disp_ack, bus.cpu_ready}), 0);
        check("rst mem", 32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 0);
        check("rst mem_wdata", bus.mem_wdata, 0);
        check("rst disp_data", bus.disp_data, 0);
        check("rst cpu_rdata", bus.cpu_rdata, 0);
        check("rst wait_cnt", 32'(dut.r_wait_cnt), 0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        run_contention();
        run_reset_ackc();
        pv = '{1'b0, 1'b0, 12'h200, 18'h00000, 18'h15555};
        run_vec(pv, "post_rst");

        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    bit seen = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    bus.disp_addr = 12'($urandom);
                    bus.disp_req  = 1'b1;
                    for (int t = 0; t < 40; t++) begin
                        @(negedge clk);
                        if (bus.disp_ack) begin seen = 1'b1; break; end
                    end
                    check("rand disp_ack_seen", 32'(seen), 1);
                    bus.disp_req = 1'b0;
                end
            end
            begin
                for (int j = 0; j < 25; j++) begin
                    bit seen = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    bus.cpu_we    = 1'($urandom);
                    bus.cpu_addr  = 12'($urandom);
                    bus.cpu_wdata = 18'($urandom);
                    bus.cpu_valid = 1'b1;
                    for (int t = 0; t < 40; t++) begin
                        @(negedge clk);
                        if (bus.cpu_ready) begin seen = 1'b1; break; end
                    end
                    check("rand cpu_ready_seen", 32'(seen), 1);
                    bus.cpu_valid = 1'b0;
                end
            end
        join
        repeat (4) @(negedge clk);
        mon_en = 1'b0;

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/screen_fb_arbiter.md
SCREEN_FB_ARBITER -- requirements
Module: screen_fb_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, pixel address width (64x64 panel, 4096 pixels).
REQ-002 The block SHALL have parameter DATA_W, default 18, pixel word width (3 colours x 6-bit depth, R in [17:12], G in [11:6], B in [5:0]).
REQ-003 The block SHALL have parameter MAX_CPU_WAIT, default 4, the number of consecutive display grants allowed while a CPU request waits.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port disp_req, input, 1, display scan read request, held until disp_ack.
REQ-007 The block SHALL have port disp_addr, input, ADDR_W, display read address, stable while disp_req is high.
REQ-008 The block SHALL have port disp_ack, output, 1, one-cycle pulse marking display read complete.
REQ-009 The block SHALL have port disp_data, output, DATA_W, registered display read data.
REQ-010 The block SHALL have port cpu_valid, input, 1, CPU bus request, held until cpu_ready.
REQ-011 The block SHALL have port cpu_we, input, 1, 1 = write, 0 = read.
REQ-012 The block SHALL have port cpu_addr, input, ADDR_W, CPU address.
REQ-013 The block SHALL have port cpu_wdata, input, DATA_W, CPU write data.
REQ-014 The block SHALL have port cpu_ready, output, 1, one-cycle pulse marking CPU access complete.
REQ-015 The block SHALL have port cpu_rdata, output, DATA_W, registered CPU read data.
REQ-016 The block SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W) and mem_rdata (input, DATA_W), driving a single-port framebuffer RAM with 1-cycle synchronous read latency.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, ISSUE_D, ISSUE_C, ACK_D, ACK_C.
REQ-018 In IDLE with no request pending, the FSM SHALL remain in IDLE, with mem_en = 0, disp_ack = 0 and cpu_ready = 0.
REQ-019 In IDLE with only disp_req high, the next state SHALL be ISSUE_D; with only cpu_valid high, the next state SHALL be ISSUE_C.
REQ-020 In IDLE with both requests high, the next state SHALL be ISSUE_C if wait_cnt == MAX_CPU_WAIT, otherwise ISSUE_D.
REQ-021 In ISSUE_D, the block SHALL drive mem_en = 1, mem_we = 0 and mem_addr = disp_addr for exactly one cycle, and the next state SHALL be ACK_D.
REQ-022 In ISSUE_C, the block SHALL drive mem_en = 1, mem_we = cpu_we, mem_addr = cpu_addr and mem_wdata = cpu_wdata for exactly one cycle, and the next state SHALL be ACK_C.
REQ-023 In ACK_D, the block SHALL assert disp_ack = 1, load disp_data from mem_rdata at the end of the cycle, and go to IDLE next.
REQ-024 In ACK_C, the block SHALL assert cpu_ready = 1, load cpu_rdata from mem_rdata only when cpu_we = 0, and go to IDLE next.
REQ-025 Latency SHALL be fixed: a request sampled in IDLE at cycle N gets mem_en at N+1, ack/ready at N+2, and IDLE again at N+3; throughput is 1 access per 3 cycles.
REQ-026 A requester that holds its request through the ack cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-027 disp_data and cpu_rdata SHALL hold their values until the next read of the same requester completes; CPU writes SHALL NOT change cpu_rdata.
REQ-028 wait_cnt (width clog2(MAX_CPU_WAIT+1)) SHALL increment on each IDLE-to-ISSUE_D transition while cpu_valid = 1.
REQ-029 wait_cnt SHALL clear on each IDLE-to-ISSUE_C transition, and on each IDLE-to-ISSUE_D transition while cpu_valid = 0.
REQ-030 wait_cnt SHALL saturate at MAX_CPU_WAIT.
REQ-031 mem_* outputs SHALL be registered and SHALL be zero whenever mem_en = 0.
REQ-032 At most one of disp_ack and cpu_ready SHALL be high in any cycle.
REQ-033 Inputs changing while their request is not pending SHALL have no effect.

Reset
REQ-034 While reset = 0, the FSM SHALL be in IDLE, and wait_cnt, disp_ack, cpu_ready, mem_en, mem_we, mem_addr, mem_wdata, disp_data and cpu_rdata SHALL all be 0.
REQ-035 Reset asserted mid-access SHALL abort the access with no ack or ready pulse; a write already issued in ISSUE_C SHALL NOT be retracted.
REQ-036 After reset deassertion, the first arbitration SHALL occur in the first posedge-sampled IDLE cycle.

Verification
REQ-037 Single display read: preload RAM[0x041] = 0x3F000, disp_req with disp_addr = 0x041 -> mem_en at N+1, disp_ack at N+2, disp_data = 0x3F000.
REQ-038 CPU write then read: write 0x00FC0 to 0xFFF, then read 0xFFF -> mem_we = 1 only in the write's ISSUE_C, cpu_rdata = 0x00FC0 after the second cpu_ready.
REQ-039 Contention: disp_req held continuously and cpu_valid held -> exactly 4 display acks, then 1 cpu_ready, then wait_cnt = 0, repeating.
REQ-040 Simultaneous requests with wait_cnt = 0 -> display is granted first; cpu_ready comes no later than 15 cycles after cpu_valid rises.
REQ-041 Reset asserted in ACK_C -> no cpu_ready pulse; all outputs 0 at once; IDLE after release.
REQ-042 Mutual exclusion checker over random traffic -> disp_ack & cpu_ready never both high; mem_en never high for 2 consecutive cycles.
